hash_msg_padder: RTL and testbench
==================================

Name: hash_msg_padder

Overview:
- Downstream neighbour of the coefficient-packing stage that produces the 8112-bit packed vector (1014 bytes).
- Snapshots that vector together with a 1-byte domain prefix, as required by NTRU Prime hashing.
- Emits the SHA-512 message as padded 1024-bit blocks, streamed as 64-bit big-endian words over a valid/ready handshake to the SHA-512 core.

Parameters:
- DATA_BYTES, 1014: packed input length in bytes. The input vector is 8*DATA_BYTES bits wide.
- WORD_W, 64: output word width. Fixed by SHA-512; no other value is supported.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle request; accepted only in IDLE.
- prefix_i  in  8  domain byte; sampled on an accepted start.
- hash_data  in  8112  packed vector; sampled on an accepted start. Byte k = hash_data[8k+7:8k].
- word_o  out  64  current message word; first message byte is in [63:56].
- word_valid_o  out  1  word_o is valid.
- word_ready_i  in  1  consumer accepts word_o this cycle.
- block_last_o  out  1  word_o is word 15 of its block.
- msg_last_o  out  1  word_o is the final word of the message.
- block_idx_o  out  4  index of the current block, 0..8.
- busy  out  1  high from the cycle after an accepted start until the final word is accepted.
- done  out  1  one-cycle pulse on the cycle after the final word is accepted.

Behaviour:
- Message layout:
  - L = DATA_BYTES + 1 = 1015 bytes.
  - Padded length = 1152 bytes = 9 blocks = 144 words.
  - Message byte n:
    - n = 0: prefix.
    - n = 1..1014: hash byte n-1.
    - n = 1015: 0x80.
    - n = 1016..1135: 0x00.
    - n = 1136..1151: 128-bit big-endian bit length 8*L = 8120 = 0x1FB8.
- Word index w (0..143) carries bytes 8w..8w+7, with byte 8w in [63:56].
- Reset values: all outputs 0, FSM in IDLE, word counter 0.
- FSM states:
  - IDLE: on start, capture prefix_i and hash_data into an internal register; go to STREAM; clear the word counter.
  - STREAM: word_valid_o = 1. On word_valid_o & word_ready_i, the word counter increments. If w = 143, go to DONE.
  - DONE: done = 1 for exactly one cycle, then return to IDLE.
- Latency: start accepted at cycle 0 gives word 0 valid at cycle 1.
- Handshake rules:
  - word_o, block_last_o, msg_last_o and block_idx_o are stable while valid & !ready.
  - valid never drops before acceptance.
  - Zero-bubble streaming: with ready held high, one word per cycle; 144 cycles from first valid to last acceptance.
- Derived outputs:
  - block_idx_o = w[7:4] (w / 16).
  - block_last_o = (w[3:0] == 15).
  - msg_last_o = (w == 143).
- start while busy or in DONE is ignored. The snapshot is not disturbed.
- Upstream inputs (hash_data, prefix_i) may change freely after the start cycle without affecting output.
- rst mid-stream returns to IDLE next cycle: valid and busy low, no done pulse.
- rst and start asserted in the same cycle: rst wins.
- word_ready_i while not valid has no effect.

Decomposition:
- Package hash_msg_pkg holds:
  - MSG_BYTES = 1015
  - PAD_WORDS = 144
  - LEN_BITS = 128'd8120
  - PAD_BYTE = 8'h80
  - The FSM state enum {IDLE, STREAM, DONE}.
- Sub-module hash_pad_word (combinational):
  - Inputs: snapshot, prefix, word index.
  - Output: the 64-bit word, per the byte map above.
- Top level: FSM, counter, snapshot register, handshake.

Test Plan:
- prefix 0x03, hash byte k = k mod 256, ready = 1 -> word 0 = 0x0300010203040506 at cycle 1; words 0..143 on consecutive cycles; done at last acceptance + 1.
- Same stimulus -> word 126 = bytes 1008..1015 = 0xEFF0F1F2F3F4F580 (hash bytes 1007..1013, then pad); words 127..141 = 0.
- Same stimulus -> word 143 = 0x0000000000001FB8 with msg_last_o = block_last_o = 1 and block_idx_o = 8; word 15 has block_last_o = 1 and block_idx_o = 0.
- ready toggled 1-0-0-1 pseudo-randomly -> word_o stable during stalls; exactly 144 acceptances; sequence identical to the ready = 1 run.
- start re-pulsed at word 50 with a different hash_data and prefix -> ignored; output unchanged; busy stays 1.
- rst at word 70 -> next cycle valid = 0, busy = 0, no done; a new start then yields word 0 again at start + 1.

Source files
------------

// File: rtl/hash_msg_padder_pkg.sv
// Shared constants, state encoding and snapshot layout for the SHA-512 message padder.
package hash_msg_pkg;

    localparam int HASH_BYTES = 1014;
    localparam int MSG_BYTES  = 1015;
    localparam int PAD_BYTES  = 1152;
    localparam int PAD_WORDS  = 144;

    localparam logic [127:0] LEN_BITS = 128'd8120;
    localparam logic [7:0]   PAD_BYTE = 8'h80;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        DONE   = 2'd2
    } pad_state_e;

    typedef struct packed {
        logic [7:0]                  prefix;
        logic [HASH_BYTES-1:0][7:0]  data;
    } msg_snap_t;

endpackage

// File: rtl/hash_msg_padder_word.sv
// Combinational byte mapper: builds one big-endian 64-bit word of the padded message.
module hash_pad_word
    import hash_msg_pkg::*;
#(
    parameter int DATA_BYTES = HASH_BYTES,
    parameter int WORD_W     = 64
) (
    input  logic [DATA_BYTES-1:0][7:0] snap,
    input  logic [7:0]                 prefix,
    input  logic [7:0]                 widx,
    output logic [WORD_W-1:0]          word
);

    localparam int LANES = WORD_W / 8;

    logic [15:0][7:0] len_bytes;
    assign len_bytes = LEN_BITS;

    for (genvar j = 0; j < LANES; j++) begin : g_lane
        logic [10:0] n;
        logic [9:0]  hb;
        logic [3:0]  lb;
        logic [7:0]  lane;

        // Message byte number is simply the word index with the lane appended.
        assign n  = {widx, 3'(j)};
        assign hb = 10'(n - 11'd1);
        assign lb = 4'(11'(PAD_BYTES - 1) - n);

        always_comb begin
            lane = 8'h00;
            if (n == 11'd0)
                lane = prefix;
            else if (n <= 11'(DATA_BYTES))
                lane = snap[hb];
            else if (n == 11'(MSG_BYTES))
                lane = PAD_BYTE;
            else if (n >= 11'(PAD_BYTES - 16))
                lane = len_bytes[lb];
        end

        assign word[8*(LANES-1-j) +: 8] = lane;
    end

endmodule

// File: rtl/hash_msg_padder.sv
// Snapshots prefix + packed vector on start and streams the padded SHA-512 message word by word.
module hash_msg_padder
    import hash_msg_pkg::*;
#(
    parameter int DATA_BYTES = 1014,
    parameter int WORD_W     = 64
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [7:0]              prefix_i,
    input  logic [8*DATA_BYTES-1:0] hash_data,
    output logic [WORD_W-1:0]       word_o,
    output logic                    word_valid_o,
    input  logic                    word_ready_i,
    output logic                    block_last_o,
    output logic                    msg_last_o,
    output logic [3:0]              block_idx_o,
    output logic                    busy,
    output logic                    done
);

    pad_state_e        state;
    logic [7:0]        widx;
    msg_snap_t         snap;
    logic [WORD_W-1:0] word;
    logic              valid;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            widx  <= '0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    state <= STREAM;
                    widx  <= '0;
                end
                STREAM: if (word_ready_i) begin
                    if (widx == 8'(PAD_WORDS - 1))
                        state <= DONE;
                    else
                        widx <= widx + 8'd1;
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Snapshot is only taken in IDLE so later starts or upstream changes cannot disturb a stream.
    always_ff @(posedge clk) begin
        if (!rst && state == IDLE && start) begin
            snap.prefix <= prefix_i;
            snap.data   <= hash_data;
        end
    end

    hash_pad_word #(
        .DATA_BYTES (DATA_BYTES),
        .WORD_W     (WORD_W)
    ) u_word (
        .snap   (snap.data),
        .prefix (snap.prefix),
        .widx   (widx),
        .word   (word)
    );

    assign valid        = (state == STREAM);
    assign word_valid_o = valid;
    assign busy         = valid;
    assign done         = (state == DONE);
    assign word_o       = valid ? word : '0;
    assign block_idx_o  = valid ? widx[7:4] : 4'd0;
    assign block_last_o = valid && (widx[3:0] == 4'hF);
    assign msg_last_o   = valid && (widx == 8'(PAD_WORDS - 1));

endmodule

// File: tb/tb_hash_msg_padder.sv
// Randomized bench for hash_msg_padder against a byte-array model of the padded message.
module tb_hash_msg_padder;

    logic          clk = 1'b0;
    logic          rst, start, word_ready_i;
    logic [7:0]    prefix_i;
    logic [8111:0] hash_data;
    logic [63:0]   word_o;
    logic          word_valid_o, block_last_o, msg_last_o, busy, done;
    logic [3:0]    block_idx_o;

    int total = 0;
    int bad   = 0;

    logic [7:0]    msg   [1152];
    logic [63:0]   got_w [144];
    logic [63:0]   ref_w [144];
    logic [8111:0] da, dr;
    logic [7:0]    pr;
    int            cyc;

    hash_msg_padder dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .prefix_i     (prefix_i),
        .hash_data    (hash_data),
        .word_o       (word_o),
        .word_valid_o (word_valid_o),
        .word_ready_i (word_ready_i),
        .block_last_o (block_last_o),
        .msg_last_o   (msg_last_o),
        .block_idx_o  (block_idx_o),
        .busy         (busy),
        .done         (done)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Padded message as a flat byte list, straight from the layout rules.
    task automatic build_msg(input logic [7:0] pfx, input logic [8111:0] d);
        logic [127:0] len;
        len = 128'd8120;
        for (int n = 0; n < 1152; n++) begin
            if (n == 0)         msg[n] = pfx;
            else if (n <= 1014) msg[n] = d[8*(n-1) +: 8];
            else if (n == 1015) msg[n] = 8'h80;
            else if (n < 1136)  msg[n] = 8'h00;
            else                msg[n] = len[8*(1151-n) +: 8];
        end
    endtask

    function automatic logic [63:0] exp_word(input int w);
        logic [63:0] r;
        r = '0;
        for (int j = 0; j < 8; j++) r = {r[55:0], msg[8*w+j]};
        return r;
    endfunction

    task automatic rand_data(output logic [7:0] p, output logic [8111:0] d);
        p = 8'($urandom);
        for (int k = 0; k < 1014; k++) d[8*k +: 8] = 8'($urandom);
    endtask

    // Called at a negedge; start is taken on the following posedge, then upstream is scrambled.
    task automatic kick(input logic [7:0] p, input logic [8111:0] d);
        prefix_i  = p;
        hash_data = d;
        start     = 1'b1;
        @(negedge clk);
        start     = 1'b0;
        prefix_i  = ~p;
        hash_data = ~d;
    endtask

    task automatic stream(input int mode, input int repulse_at, input int rst_at, output int cycles);
        int   w;
        logic acc;
        logic [7:0]    rp;
        logic [8111:0] rd;
        w = 0;
        cycles = 0;
        while (w < 144 && cycles < 1000) begin
            chk("valid", 64'(word_valid_o), 64'd1);
            chk("busy", 64'(busy), 64'd1);
            chk("done_mid", 64'(done), 64'd0);
            chk($sformatf("word%0d", w), word_o, exp_word(w));
            chk("blk_idx", 64'(block_idx_o), 64'(w / 16));
            chk("blk_last", 64'(block_last_o), 64'((w % 16) == 15));
            chk("msg_last", 64'(msg_last_o), 64'(w == 143));
            if (w == repulse_at) begin
                rand_data(rp, rd);
                prefix_i  = rp;
                hash_data = rd;
                start     = 1'b1;
            end
            if (w == rst_at) begin
                rst = 1'b1;
                start = 1'b1;
                word_ready_i = 1'b1;
                @(negedge clk);
                rst = 1'b0;
                start = 1'b0;
                chk("rst_valid", 64'(word_valid_o), 64'd0);
                chk("rst_busy", 64'(busy), 64'd0);
                chk("rst_done", 64'(done), 64'd0);
                @(negedge clk);
                chk("rst_done2", 64'(done), 64'd0);
                chk("rst_valid2", 64'(word_valid_o), 64'd0);
                return;
            end
            word_ready_i = (mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
            acc = word_ready_i && word_valid_o;
            if (acc) got_w[w] = word_o;
            @(negedge clk);
            start = 1'b0;
            cycles++;
            if (acc) w++;
        end
        chk("stream_bound", 64'(cycles < 1000), 64'd1);
        chk("done_pulse", 64'(done), 64'd1);
        chk("end_valid", 64'(word_valid_o), 64'd0);
        chk("end_busy", 64'(busy), 64'd0);
        word_ready_i = 1'b1;
        @(negedge clk);
        chk("done_once", 64'(done), 64'd0);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; word_ready_i = 1'b0;
        prefix_i = '0; hash_data = '0;
        @(negedge clk);
        @(negedge clk);
        chk("rst_word", word_o, 64'd0);
        chk("rst_valid0", 64'(word_valid_o), 64'd0);
        chk("rst_busy0", 64'(busy), 64'd0);
        chk("rst_done0", 64'(done), 64'd0);
        chk("rst_idx", 64'(block_idx_o), 64'd0);
        chk("rst_flags", 64'({block_last_o, msg_last_o}), 64'd0);
        rst = 1'b0;
        word_ready_i = 1'b1;
        repeat (3) @(negedge clk);
        chk("idle_ready", 64'(word_valid_o), 64'd0);

        // Run A: counting pattern, ready held high.
        for (int k = 0; k < 1014; k++) da[8*k +: 8] = 8'(k % 256);
        build_msg(8'h03, da);
        kick(8'h03, da);
        stream(0, -1, -1, cyc);
        chk("zero_bubble", 64'(cyc), 64'd144);
        chk("w0_const", got_w[0], 64'h0300010203040506);
        chk("w126_const", got_w[126], 64'hEFF0F1F2F3F4F580);
        chk("w143_const", got_w[143], 64'h0000000000001FB8);
        for (int i = 127; i <= 141; i++) chk($sformatf("zero_w%0d", i), got_w[i], 64'd0);
        for (int i = 0; i < 144; i++) ref_w[i] = got_w[i];

        // Run B: same stimulus, random stalls, ignored re-start at word 50.
        build_msg(8'h03, da);
        kick(8'h03, da);
        stream(1, 50, -1, cyc);
        for (int i = 0; i < 144; i++) chk($sformatf("replay%0d", i), got_w[i], ref_w[i]);

        // Run C: random data, reset mid-stream at word 70.
        rand_data(pr, dr);
        build_msg(pr, dr);
        kick(pr, dr);
        stream(1, -1, 70, cyc);

        // Run D: fresh start after the reset.
        rand_data(pr, dr);
        build_msg(pr, dr);
        kick(pr, dr);
        stream(0, -1, -1, cyc);
        chk("zero_bubble2", 64'(cyc), 64'd144);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
